// File: rtl/ws2811_rx_pkg.sv
// Shared WS2811 timing constants, FSM state type and sizing helpers for the receiver.
// Pulse widths are kept in nanoseconds and scaled to clk cycles where they are used.
package ws2811_rx_pkg;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_t;

    // Nominal line timing, shared with the strip driver.
    localparam int T0H_NS           = 500;
    localparam int T0L_NS           = 2000;
    localparam int T1H_NS           = 1200;
    localparam int T1L_NS           = 1300;
    localparam int RESET_NS         = 50000;

    // Receiver decision points.
    localparam int BIT_THRESHOLD_NS = 850;
    localparam int MAX_HIGH_NS      = 2000;
    localparam int RESET_DETECT_NS  = 50000;

    function automatic int microsecond_count(input int sys_clk);
        return sys_clk / 1_000_000;
    endfunction

    function automatic int ns_to_cycles(input int sys_clk, input int ns);
        return microsecond_count(sys_clk) * ns / 1000;
    endfunction

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2811_rx_if.sv
// Decoded pixel stream out of the WS2811 receiver: address, colours and event strobes.
// master drives (receiver), slave observes (consumer / checker).
interface ws2811_rx_if
    import ws2811_rx_pkg::*;
#(
    parameter int NUM_LEDS = 4
) ();
    localparam int AW = addr_width(NUM_LEDS);

    logic [AW-1:0] address;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          valid;
    logic          frame_done;
    logic          error;

    modport master (
        output address, red, green, blue, valid, frame_done, error
    );

    modport slave (
        input address, red, green, blue, valid, frame_done, error
    );
endinterface

// File: rtl/ws2811_sync.sv
// Generic two-flop synchronizer for asynchronous inputs, clears to 0 on reset.
// Two clk cycles of latency from d to q.
module ws2811_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ws2811_rx.sv
// WS2811 line decoder: classifies pulses by high time, assembles 24-bit RGB pixels with LED address.
// Outputs are registered; valid/frame_done land 3 clk edges after the qualifying DI event.
module ws2811_rx
    import ws2811_rx_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int SYSTEM_CLOCK = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DI,
    ws2811_rx_if.master px
);
    localparam int AW                  = addr_width(NUM_LEDS);
    localparam int BIT_THRESHOLD_COUNT = ns_to_cycles(SYSTEM_CLOCK, BIT_THRESHOLD_NS);
    localparam int MAX_HIGH_COUNT      = ns_to_cycles(SYSTEM_CLOCK, MAX_HIGH_NS);
    localparam int RESET_DETECT_COUNT  = ns_to_cycles(SYSTEM_CLOCK, RESET_DETECT_NS);
    localparam int CW                  = $clog2(RESET_DETECT_COUNT) + 1;

    localparam logic [CW-1:0] THRESHOLD = CW'(BIT_THRESHOLD_COUNT);
    localparam logic [CW-1:0] HIGH_LAST = CW'(MAX_HIGH_COUNT - 1);
    localparam logic [CW-1:0] GAP_COUNT = CW'(RESET_DETECT_COUNT);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_LEDS - 1);

    logic          di_s;
    rx_state_t     state;
    logic [CW-1:0] high_count;
    logic [CW-1:0] low_count;
    logic [4:0]    bit_count;
    logic [23:0]   shift;
    logic [23:0]   shift_next;
    logic [AW-1:0] address;
    logic [7:0]    red, green, blue;
    logic          valid, frame_done, error;

    ws2811_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (DI),
        .q     (di_s)
    );

    // Inclusive threshold: a high of exactly BIT_THRESHOLD_COUNT samples is a 1.
    assign shift_next = {shift[22:0], (high_count >= THRESHOLD)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SYNC;
            high_count <= '0;
            low_count  <= '0;
            bit_count  <= '0;
            shift      <= '0;
            address    <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            if (valid) begin
                address <= (address == ADDR_LAST) ? '0 : address + 1'b1;
            end

            case (state)
                // A completed gap is checked before di_s so it wins a coincident rise.
                ST_SYNC: begin
                    if (low_count == GAP_COUNT) begin
                        state      <= ST_IDLE;
                        low_count  <= '0;
                        address    <= '0;
                        frame_done <= 1'b1;
                    end else if (di_s) begin
                        low_count <= '0;
                    end else begin
                        low_count <= low_count + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (di_s) begin
                        state      <= ST_HIGH;
                        high_count <= CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (di_s) begin
                        if (high_count == HIGH_LAST) begin
                            error      <= 1'b1;
                            state      <= ST_SYNC;
                            high_count <= '0;
                            low_count  <= '0;
                            bit_count  <= '0;
                            shift      <= '0;
                        end else begin
                            high_count <= high_count + 1'b1;
                        end
                    end else begin
                        shift      <= shift_next;
                        high_count <= '0;
                        low_count  <= CW'(1);
                        state      <= ST_LOW;
                        if (bit_count == 5'd23) begin
                            red       <= shift_next[23:16];
                            green     <= shift_next[15:8];
                            blue      <= shift_next[7:0];
                            valid     <= 1'b1;
                            bit_count <= '0;
                        end else begin
                            bit_count <= bit_count + 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (low_count == GAP_COUNT) begin
                        frame_done <= 1'b1;
                        error      <= (bit_count != '0);
                        address    <= '0;
                        state      <= ST_IDLE;
                        low_count  <= '0;
                        bit_count  <= '0;
                        shift      <= '0;
                    end else if (di_s) begin
                        state      <= ST_HIGH;
                        high_count <= CW'(1);
                        low_count  <= '0;
                    end else begin
                        low_count <= low_count + 1'b1;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    assign px.address    = address;
    assign px.red        = red;
    assign px.green      = green;
    assign px.blue       = blue;
    assign px.valid      = valid;
    assign px.frame_done = frame_done;
    assign px.error      = error;

endmodule
